// File: rtl/iir1_pkg.sv
// Shared definitions for the first-order IIR stream filter: default widths,
// FSM state encoding and the output saturation helpers.
package iir1_pkg;

    localparam int DEF_X_W     = 8;
    localparam int DEF_Y_W     = 32;
    localparam int DEF_C_W     = 16;
    localparam int DEF_FRAC    = 0;
    localparam int DEF_MUL_LAT = 2;
    localparam int MUL_LAT_MIN = 1;

    // Working width of the saturation helpers. Any accumulator of P bits
    // (P = Y_W + C_W + 1) is sign-extended to this width first, so P must
    // not exceed it.
    localparam int SAT_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUM  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Largest value representable in a signed y_w-bit word.
    function automatic logic signed [SAT_W-1:0] sat_max(input int y_w);
        return (SAT_W'(1) <<< (y_w - 1)) - SAT_W'(1);
    endfunction

    // True when v (a sign-extended P-bit value) does not fit in y_w bits.
    function automatic logic sat_hit(input logic signed [SAT_W-1:0] v,
                                     input int y_w);
        return (v > sat_max(y_w)) || (v < ~sat_max(y_w));
    endfunction

    // v clipped to [-2^(y_w-1), 2^(y_w-1)-1]; the caller keeps the low y_w bits.
    function automatic logic signed [SAT_W-1:0] sat_clip(input logic signed [SAT_W-1:0] v,
                                                         input int y_w);
        if (v > sat_max(y_w)) begin
            return sat_max(y_w);
        end
        if (v < ~sat_max(y_w)) begin
            return ~sat_max(y_w);
        end
        return v;
    endfunction

endpackage

// File: rtl/iir1_stream_mult_pipe.sv
// Signed multiplier followed by a LAT-deep register pipeline. The product of
// the operands present at edge t appears on p after edge t+LAT.
module mult_pipe #(
    parameter int A_W = 16,
    parameter int B_W = 32,
    parameter int LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [A_W-1:0]    a,
    input  logic signed [B_W-1:0]    b,
    output logic signed [A_W+B_W-1:0] p
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] pipe_q [LAT];

    // Both operands are sign-extended to the full product width first.
    assign prod = P_W'(a) * P_W'(b);

    // Free-running product pipeline; cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= prod;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign p = pipe_q[LAT-1];

endmodule

// File: rtl/iir1_stream.sv
// First-order IIR filter y[n] = a*y[n-1] + b*x[n] with run-time signed
// fixed-point coefficients, stream handshakes on both sides, a pipelined
// multiplier and saturating output. Holds the feedback state y[n-1].
module iir1_stream
    import iir1_pkg::*;
#(
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int C_W     = DEF_C_W,
    parameter int FRAC    = DEF_FRAC,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic signed [C_W-1:0] a_coef,
    input  logic signed [C_W-1:0] b_coef,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [X_W-1:0] x_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [Y_W-1:0] y_out,
    output logic                  sat,
    output state_t                dbg_state
);

    // Full accumulator width: a*y needs C_W+Y_W bits, one more for the add.
    localparam int P       = Y_W + C_W + 1;
    localparam int LAT_EFF = (MUL_LAT < MUL_LAT_MIN) ? MUL_LAT_MIN : MUL_LAT;
    localparam int CNT_W   = $clog2(LAT_EFF + 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic signed [X_W-1:0]  x_q;
    logic signed [C_W-1:0]  a_q;
    logic signed [C_W-1:0]  b_q;
    logic signed [Y_W-1:0]  y_state;

    logic signed [C_W+Y_W-1:0] prod_ay;
    logic signed [C_W+X_W-1:0] prod_bx;
    logic signed [P-1:0]       acc;
    logic signed [P-1:0]       acc_sh;
    logic signed [SAT_W-1:0]   acc_wide;
    logic signed [Y_W-1:0]     y_next;
    logic                      sat_next;

    // Handshake rule for both ports: a transfer happens on a rising edge where
    // valid and ready are both high; a source holding valid keeps its data
    // stable until that edge, and valid never waits on ready. in_ready is
    // combinational from out_ready so a new sample can enter on the same edge
    // the previous result leaves.
    assign in_ready  = reset && ((state == IDLE) || ((state == OUT) && out_ready));
    assign dbg_state = state;

    // a * y[n-1]: y_state is stable from SUM of one sample until the next one's SUM.
    mult_pipe #(
        .A_W (C_W),
        .B_W (Y_W),
        .LAT (LAT_EFF)
    ) u_mul_ay (
        .clk   (clk),
        .reset (reset),
        .a     (a_q),
        .b     (y_state),
        .p     (prod_ay)
    );

    // b * x[n] from the operands captured at acceptance.
    mult_pipe #(
        .A_W (C_W),
        .B_W (X_W),
        .LAT (LAT_EFF)
    ) u_mul_bx (
        .clk   (clk),
        .reset (reset),
        .a     (b_q),
        .b     (x_q),
        .p     (prod_bx)
    );

    // Sum at full width, floor-shift out the fractional bits, then clip.
    assign acc      = P'(prod_ay) + P'(prod_bx);
    assign acc_sh   = acc >>> FRAC;
    assign acc_wide = SAT_W'(acc_sh);
    assign y_next   = Y_W'(sat_clip(acc_wide, Y_W));
    assign sat_next = sat_hit(acc_wide, Y_W);

    // Control FSM with latency counter, operand capture and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            x_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            y_state   <= '0;
            y_out     <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            y_state   <= '0;
            y_out     <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q   <= x_in;
                        a_q   <= a_coef;
                        b_q   <= b_coef;
                        cnt   <= CNT_W'(LAT_EFF - 1);
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (cnt == '0) begin
                        state <= SUM;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SUM: begin
                    y_out     <= y_next;
                    y_state   <= y_next;
                    sat       <= sat_next;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            x_q   <= x_in;
                            a_q   <= a_coef;
                            b_q   <= b_coef;
                            cnt   <= CNT_W'(LAT_EFF - 1);
                            state <= MUL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir1_stream.sv
// Bench for iir1_stream: three instances (integer defaults, FRAC=8, Y_W=8)
// run in lockstep from shared handshake controls with per-instance data.
module tb_iir1_stream;
    import iir1_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset, clear, in_valid, out_ready;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic signed [15:0] a0, b0, a1, b1, a2, b2;
    logic signed [7:0]  x0, x1, x2;
    logic in_ready0, in_ready1, in_ready2;
    logic out_valid0, out_valid1, out_valid2;
    logic signed [31:0] y0, y1;
    logic signed [7:0]  y2;
    logic sat0, sat1, sat2;
    state_t st0, st1, st2;

    iir1_stream u_def (
        .clk(clk), .reset(reset), .clear(clear), .a_coef(a0), .b_coef(b0),
        .in_valid(in_valid), .in_ready(in_ready0), .x_in(x0),
        .out_valid(out_valid0), .out_ready(out_ready), .y_out(y0), .sat(sat0),
        .dbg_state(st0)
    );

    iir1_stream #(.FRAC(8)) u_frac (
        .clk(clk), .reset(reset), .clear(clear), .a_coef(a1), .b_coef(b1),
        .in_valid(in_valid), .in_ready(in_ready1), .x_in(x1),
        .out_valid(out_valid1), .out_ready(out_ready), .y_out(y1), .sat(sat1),
        .dbg_state(st1)
    );

    iir1_stream #(.Y_W(8)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .a_coef(a2), .b_coef(b2),
        .in_valid(in_valid), .in_ready(in_ready2), .x_in(x2),
        .out_valid(out_valid2), .out_ready(out_ready), .y_out(y2), .sat(sat2),
        .dbg_state(st2)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // y = clip(floor((a*y_prev + b*x) / 2^frac)) to y_w signed bits.
    function automatic longint model_next(input longint y_prev, input longint a,
                                          input longint b, input longint x,
                                          input int frac, input int y_w,
                                          output bit clipped);
        longint num, d, q, hi, lo;
        num = a * y_prev + b * x;
        d   = longint'(1) << frac;
        q   = num / d;
        if ((num % d != 0) && (num < 0)) q = q - 1;
        hi  = (longint'(1) << (y_w - 1)) - 1;
        lo  = -hi - 1;
        clipped = 1'b0;
        if (q > hi) begin
            q = hi;
            clipped = 1'b1;
        end else if (q < lo) begin
            q = lo;
            clipped = 1'b1;
        end
        return q;
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [8:0]  exp_q2[$];
    int          lat_q[$];
    longint m_y0 = 0, m_y1 = 0, m_y2 = 0;
    int     n_acc = 0;
    int     last_acc = 0;
    logic   ov_prev = 1'b0;
    longint ny;
    bit     s;
    logic [32:0] e0, e1;
    logic [8:0]  e2;

    always @(negedge clk) begin
        if (!reset || clear) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_q2.delete();
            lat_q.delete();
            m_y0 = 0;
            m_y1 = 0;
            m_y2 = 0;
        end else begin
            if (in_valid && in_ready0) begin
                n_acc++;
                last_acc = cyc + 1;
                lat_q.push_back(cyc + 1);
                check("rdy1_lockstep", in_ready1, 1);
                check("rdy2_lockstep", in_ready2, 1);
                ny = model_next(m_y0, a0, b0, x0, 0, 32, s);
                m_y0 = ny;
                exp_q0.push_back({s, ny[31:0]});
                ny = model_next(m_y1, a1, b1, x1, 8, 32, s);
                m_y1 = ny;
                exp_q1.push_back({s, ny[31:0]});
                ny = model_next(m_y2, a2, b2, x2, 0, 8, s);
                m_y2 = ny;
                exp_q2.push_back({s, ny[7:0]});
            end
            if (out_valid0 && out_ready) begin
                if (exp_q0.size() == 0) check("out0_unexpected", 1, 0);
                else begin
                    e0 = exp_q0.pop_front();
                    check("y0", y0, $signed(e0[31:0]));
                    check("sat0", sat0, e0[32]);
                end
            end
            if (out_valid1 && out_ready) begin
                if (exp_q1.size() == 0) check("out1_unexpected", 1, 0);
                else begin
                    e1 = exp_q1.pop_front();
                    check("y1", y1, $signed(e1[31:0]));
                    check("sat1", sat1, e1[32]);
                end
            end
            if (out_valid2 && out_ready) begin
                if (exp_q2.size() == 0) check("out2_unexpected", 1, 0);
                else begin
                    e2 = exp_q2.pop_front();
                    check("y2", y2, $signed(e2[7:0]));
                    check("sat2", sat2, e2[8]);
                end
            end
            if (out_valid0 && !ov_prev) begin
                if (lat_q.size() == 0) check("lat_unexpected", 1, 0);
                else check("latency", cyc - lat_q.pop_front(), 3);
            end
        end
        ov_prev = out_valid0;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int v0, input int v1, input int v2);
        int base;
        bit ok;
        base = n_acc;
        ok = 1'b0;
        x0 = 8'(v0);
        x1 = 8'(v1);
        x2 = 8'(v2);
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (n_acc != base) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        check("accept", ok, 1);
    endtask

    task automatic wait_out(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic clear_pulse();
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    function automatic logic signed [15:0] rand_coef();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 1023)) - 16'sd512;
    endfunction

    task automatic rand_ctrl();
        out_ready = ($urandom_range(0, 3) != 0);
        a0 = rand_coef();
        b0 = rand_coef();
        a1 = rand_coef();
        b1 = rand_coef();
        a2 = rand_coef();
        b2 = rand_coef();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int     x0;
        longint y0;
        int     x1;
        longint y1;
        int     x2;
        longint y2;
        bit     s2;
    } vec_t;

    vec_t tbl[4];
    int   acc_e[4];

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        int base;
        bit ok;

        tbl[0] = '{1, 3,  10, 10, 100,  100, 1'b0};
        tbl[1] = '{1, 9,  10, 15, 100,  127, 1'b1};
        tbl[2] = '{1, 21, 10, 17, -128, -1,  1'b0};
        tbl[3] = '{1, 45, 10, 18, 0,    -1,  1'b0};

        reset = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x0 = '0; x1 = '0; x2 = '0;
        a0 = 16'sd2;   b0 = 16'sd3;
        a1 = 16'sd128; b1 = 16'sd256;
        a2 = 16'sd1;   b2 = 16'sd1;
        #1 reset = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready", in_ready0, 0);
        check("rst_out_valid", out_valid0, 0);
        check("rst_y_out", y0, 0);
        check("rst_sat", sat0, 0);
        check("rst_y2", y2, 0);
        check("rst_state1", st1, IDLE);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready0, 1);
        check("post_rst_state", st0, IDLE);
        check("post_rst_state2", st2, IDLE);
        @(posedge clk);
        #1;

        // table: defaults, FRAC=8 floor rounding, Y_W=8 clipping feedback
        for (int r = 0; r < 4; r++) begin
            send(tbl[r].x0, tbl[r].x1, tbl[r].x2);
            wait_out("tbl_out");
            check("tbl_y0", y0, tbl[r].y0);
            check("tbl_sat0", sat0, 0);
            check("tbl_y1", y1, tbl[r].y1);
            check("tbl_sat1", sat1, 0);
            check("tbl_y2", y2, tbl[r].y2);
            check("tbl_sat2", sat2, tbl[r].s2);
            @(posedge clk);
            #1;
        end

        // back-to-back stream: one sample per 4 cycles
        clear_pulse();
        for (int k = 0; k < 4; k++) begin
            send(1, 0, 0);
            acc_e[k] = last_acc;
            if (k > 0) check("period", acc_e[k] - acc_e[k-1], 4);
        end
        wait_out("stream_last");
        check("stream_y", y0, 45);
        repeat (3) @(posedge clk);
        #1;

        // back-pressure: y=3 held for 5 cycles, next sample enters on release
        clear_pulse();
        send(1, 0, 0);
        out_ready = 1'b0;
        wait_out("bp_out");
        @(posedge clk);
        #1;
        x0 = 8'sd1; x1 = '0; x2 = '0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_y_hold", y0, 3);
            check("bp_valid_hold", out_valid0, 1);
            check("bp_in_ready", in_ready0, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        base = n_acc;
        @(negedge clk);
        check("bp_release_ready", in_ready0, 1);
        @(posedge clk);
        #1;
        check("bp_same_edge_accept", n_acc, base + 1);
        check("bp_state_mul", st0, MUL);
        check("bp_out_consumed", out_valid0, 0);
        in_valid = 1'b0;
        wait_out("bp_next");
        check("bp_next_y", y0, 9);
        @(posedge clk);
        #1;

        // clear during MUL drops the sample in flight
        clear_pulse();
        send(1, 0, 0);
        wait_out("clr_first");
        check("clr_first_y", y0, 3);
        @(posedge clk);
        #1;
        send(1, 0, 0);
        @(posedge clk);
        #1;
        check("clr_in_mul", st0, MUL);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid0) seen = 1'b1;
        end
        check("clr_dropped", seen, 0);
        check("clr_y_zero", y0, 0);
        @(posedge clk);
        #1;
        send(1, 0, 0);
        wait_out("clr_after");
        check("clr_after_y", y0, 3);
        @(posedge clk);
        #1;

        // reset asserted during SUM
        send(1, 0, 0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (st0 == SUM) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        check("rst_reach_sum", ok, 1);
        check("pre_rst_y", y0, 3);
        reset = 1'b0;
        #1;
        check("arst_y", y0, 0);
        check("arst_valid", out_valid0, 0);
        check("arst_sat", sat0, 0);
        check("arst_in_ready", in_ready0, 0);
        check("arst_state", st0, IDLE);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        check("arst_release_ready", in_ready0, 1);
        @(posedge clk);
        #1;
        send(1, 0, 0);
        wait_out("arst_after");
        check("arst_after_y", y0, 3);
        @(posedge clk);
        #1;

        // randomized traffic, coefficients changing every cycle
        clear_pulse();
        for (int n = 0; n < 150; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                rand_ctrl();
            end
            x0 = 8'($urandom);
            x1 = 8'($urandom);
            x2 = 8'($urandom);
            in_valid = 1'b1;
            base = n_acc;
            ok = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(posedge clk);
                if (n_acc != base) begin
                    ok = 1'b1;
                    break;
                end
                #1;
                rand_ctrl();
            end
            #1;
            in_valid = 1'b0;
            rand_ctrl();
            if (!ok) check("rand_accept", ok, 1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && exp_q2.size() == 0) break;
        end
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);
        check("drain_q2", exp_q2.size(), 0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iir1_stream.md
# iir1_stream

Parametrised first-order IIR filter, y[n] = a·y[n-1] + b·x[n], with signed fixed-point coefficients supplied at run time, a valid/ready stream interface on both sides, configurable multiplier pipeline depth and output saturation. It is the next generation of the team's fixed-coefficient integer filter. It sits between a sample source (ADC or upstream DSP stage) and any back-pressuring consumer. It owns the feedback state y[n-1].

## Interface
Parameters:
- X_W, 8: input sample width, signed two's complement.
- Y_W, 32: output/state width, signed.
- C_W, 16: coefficient width, signed.
- FRAC, 0: fractional bits of the coefficients. 0 means integer coefficients.
- MUL_LAT, 2: multiplier pipeline latency in cycles. Must be ≥1.

Ports:
- clk, in, 1: clock. All state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- clear, in, 1: synchronous. Aborts any sample in flight and zeroes y[n-1].
- a_coef, in, C_W: feedback coefficient, signed.
- b_coef, in, C_W: feed-forward coefficient, signed.
- in_valid, in, 1: x_in is valid.
- in_ready, out, 1: the filter accepts a sample.
- x_in, in, X_W: input sample, signed.
- out_valid, out, 1: y_out is valid.
- out_ready, in, 1: the consumer accepts y_out.
- y_out, out, Y_W: filtered sample, signed.
- sat, out, 1: y_out was clipped. Qualified by out_valid.

## Operation
- FSM states:
  - IDLE (reset state): in_ready=1. An accepted sample captures x_in, a_coef and b_coef into operand registers and moves to MUL.
  - MUL: the down-counter runs for MUL_LAT cycles, then moves to SUM.
  - SUM: the sum is registered into y_out, y_state and sat, then moves to OUT.
  - OUT: out_valid=1. On out_valid&&out_ready, moves to IDLE. If a new input handshake happens in the same cycle, moves to MUL instead.
- in_ready = (state==IDLE) || (state==OUT && out_ready). This is combinational from out_ready.
- Coefficients are sampled only at input acceptance. Changing them mid-sample has no effect on that sample.
- Arithmetic, with P = Y_W+C_W+1:
  - acc = a·y_state + b·sign_ext(x), computed at full P-bit width with no intermediate overflow.
  - acc is arithmetic-shifted right by FRAC (floor toward −∞).
  - The shifted value is saturated to [−2^(Y_W−1), 2^(Y_W−1)−1].
  - sat=1 if clipping occurred.
- y_state takes the saturated value in SUM. Feedback always uses the clipped value.
- clear has priority over all handshakes:
  - y_state, y_out and sat become 0, out_valid becomes 0, state becomes IDLE.
  - The sample in flight is dropped and never reaches the output.
- Reset values:
  - in_ready=0 while reset is asserted, then 1 after release (IDLE).
  - out_valid=0, y_out=0, sat=0, y_state=0.
  - Multiplier pipeline registers are 0.
- Reset asserted mid-sample aborts it immediately and asynchronously. No output is produced for that sample.

## Timing
- Input accepted at edge t. Products are valid after edge t+MUL_LAT. y_out/out_valid are registered at edge t+MUL_LAT+1.
- Latency is MUL_LAT+1 cycles from input handshake to out_valid.
- Maximum throughput, with out_ready held high, is one sample per MUL_LAT+2 cycles.
- Under back-pressure, y_out and sat are held stable while out_valid=1 && out_ready=0.
- in_valid may be asserted while in_ready=0. The sample is held by the source, and no sample is lost or duplicated.
- Simultaneous clear with an input handshake: clear wins, and the sample is discarded.

## Structure
- Package iir1_pkg:
  - Default widths and the MUL_LAT lower bound.
  - FSM state enum {IDLE, MUL, SUM, OUT}.
  - A saturation function parametrised on P and Y_W.
- Sub-module mult_pipe:
  - Signed multiplier with parameter LAT, async active-low reset, operand widths as parameters.
  - Two instances: a×y_state and b×x.
- The top level holds the FSM, latency counter, operand/state registers, adder, shift and saturation.

## Test plan
- Defaults with a=2, b=3. Send x=1,1,1,1 with out_ready=1 → y=3,9,21,45. Each out_valid comes exactly 3 cycles after its input handshake, with a 4-cycle sample period.
- FRAC=8, a=128 (0.5), b=256 (1.0). Send x=10 four times → y=10,15,17,18 (floor rounding).
- Y_W=8, a=1, b=1. Send x=100,100 → y=100 then 127 with sat=1. The third x=−128 gives y=−1, because feedback uses the clipped 127.
- Back-pressure: hold out_ready=0 for 5 cycles while y=3 is valid. y_out stays stable and in_ready=0. On release, the next sample is accepted in the same cycle as the output handshake.
- clear pulsed during MUL of the x=1 second sample (a=2, b=3) → no output for that sample. The next x=1 gives y=3.
- reset asserted during SUM → all outputs are 0 asynchronously. After release, x=1 gives y=3.
